// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a ROWS x COLS MAC grid: clear, diagonally skewed operand feed,
// accumulator wait with timeout, then a row-major valid/ready drain of the results.
module systolic_array_ctrl #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int VECTOR_LENGTH = 4,
  parameter int ACC_WIDTH     = 16,
  parameter int WAIT_TIMEOUT  = 64,
  localparam int KW = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic                           pe_clear,
  output logic [ROWS-1:0]                a_feed_valid,
  output logic [ROWS*KW-1:0]             a_feed_idx,
  output logic [COLS-1:0]                b_feed_valid,
  output logic [COLS*KW-1:0]             b_feed_idx,
  input  logic [ROWS*COLS-1:0]           acc_valid_vec,
  input  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_flat,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ACC_WIDTH-1:0]           res_data,
  output logic [RW-1:0]                  res_row,
  output logic [CW-1:0]                  res_col
);

  localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS;
  localparam int T      = VECTOR_LENGTH + MAX_RC - 1;
  localparam int SW     = (T > 1) ? $clog2(T) : 1;
  localparam int TW     = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [SW-1:0] STEP_LAST  = SW'(T - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(WAIT_TIMEOUT - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [SW-1:0]         step, step_n;
  logic [TW-1:0]         timer, timer_n;
  logic [RW-1:0]         drain_row, drain_row_n;
  logic [CW-1:0]         drain_col, drain_col_n;
  logic                  error_n;
  logic                  load_beat;
  logic [ROWS-1:0]       a_valid_n;
  logic [ROWS*KW-1:0]    a_idx_n;
  logic [COLS-1:0]       b_valid_n;
  logic [COLS*KW-1:0]    b_idx_n;
  logic [ACC_WIDTH-1:0]  sel_data;

  always_comb begin
    state_n     = state;
    step_n      = step;
    timer_n     = timer;
    drain_row_n = drain_row;
    drain_col_n = drain_col;
    error_n     = error;
    load_beat   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CLEAR;
          error_n = 1'b0;
        end
      end
      S_CLEAR: begin
        state_n = S_FEED;
        step_n  = '0;
      end
      S_FEED: begin
        if (step == STEP_LAST) begin
          state_n = S_WAIT;
          step_n  = '0;
          timer_n = '0;
        end else begin
          step_n = step + 1'b1;
        end
      end
      S_WAIT: begin
        // All-valid wins over an expiring timer in the same cycle.
        if (&acc_valid_vec) begin
          state_n     = S_DRAIN;
          timer_n     = '0;
          drain_row_n = '0;
          drain_col_n = '0;
          load_beat   = 1'b1;
        end else if (timer == TIMER_LAST) begin
          state_n = S_DONE;
          timer_n = '0;
          error_n = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_DRAIN: begin
        if (res_valid && res_ready) begin
          if (drain_row == ROW_LAST && drain_col == COL_LAST) begin
            state_n     = S_DONE;
            drain_row_n = '0;
            drain_col_n = '0;
          end else begin
            load_beat = 1'b1;
            if (drain_col == COL_LAST) begin
              drain_col_n = '0;
              drain_row_n = drain_row + 1'b1;
            end else begin
              drain_col_n = drain_col + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered without lag.
  always_comb begin
    a_valid_n = '0;
    a_idx_n   = '0;
    b_valid_n = '0;
    b_idx_n   = '0;
    sel_data  = '0;
    if (state_n == S_FEED) begin
      for (int r = 0; r < ROWS; r++) begin
        if (int'(step_n) >= r && int'(step_n) < r + VECTOR_LENGTH) begin
          a_valid_n[r]          = 1'b1;
          a_idx_n[r*KW +: KW]   = KW'(int'(step_n) - r);
        end
      end
      for (int c = 0; c < COLS; c++) begin
        if (int'(step_n) >= c && int'(step_n) < c + VECTOR_LENGTH) begin
          b_valid_n[c]          = 1'b1;
          b_idx_n[c*KW +: KW]   = KW'(int'(step_n) - c);
        end
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (drain_row_n == RW'(r) && drain_col_n == CW'(c)) begin
          sel_data = acc_flat[(r*COLS + c)*ACC_WIDTH +: ACC_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      step         <= '0;
      timer        <= '0;
      drain_row    <= '0;
      drain_col    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      pe_clear     <= 1'b0;
      a_feed_valid <= '0;
      a_feed_idx   <= '0;
      b_feed_valid <= '0;
      b_feed_idx   <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_row      <= '0;
      res_col      <= '0;
    end else begin
      state        <= state_n;
      step         <= step_n;
      timer        <= timer_n;
      drain_row    <= drain_row_n;
      drain_col    <= drain_col_n;
      busy         <= (state_n != S_IDLE);
      done         <= (state_n == S_DONE);
      error        <= error_n;
      pe_clear     <= (state_n == S_CLEAR);
      a_feed_valid <= a_valid_n;
      a_feed_idx   <= a_idx_n;
      b_feed_valid <= b_valid_n;
      b_feed_idx   <= b_idx_n;
      res_valid    <= (state_n == S_DRAIN);
      // Beat payload is captured once on presentation and held through any stall.
      if (load_beat) begin
        res_data <= sel_data;
        res_row  <= drain_row_n;
        res_col  <= drain_col_n;
      end else if (state_n != S_DRAIN) begin
        res_data <= '0;
        res_row  <= '0;
        res_col  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: behavioural skewed PE grid plus a result scoreboard queue.
module tb_systolic_array_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int K    = 4;
  localparam int AW   = 16;
  localparam int TMO  = 64;
  localparam int KW   = 2;
  localparam int RW   = 2;
  localparam int CW   = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic                      res_ready = 1'b1;
  logic                      busy, done, error, pe_clear;
  logic [ROWS-1:0]           a_feed_valid;
  logic [ROWS*KW-1:0]        a_feed_idx;
  logic [COLS-1:0]           b_feed_valid;
  logic [COLS*KW-1:0]        b_feed_idx;
  logic [ROWS*COLS-1:0]      acc_valid_vec;
  logic [ROWS*COLS-1:0]      acc_valid_model;
  logic [ROWS*COLS*AW-1:0]   acc_flat;
  logic                      res_valid;
  logic [AW-1:0]             res_data;
  logic [RW-1:0]             res_row;
  logic [CW-1:0]             res_col;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [AW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic [AW-1:0]        mat_a [ROWS][K];
  logic [AW-1:0]        mat_b [K][COLS];
  logic                 force_en = 1'b0;
  logic [ROWS*COLS-1:0] force_val = '0;

  logic [AW-1:0] pe_acc [ROWS][COLS];
  int            pe_cnt [ROWS][COLS];
  logic          a_sr_v [ROWS][COLS];
  logic [KW-1:0] a_sr_i [ROWS][COLS];
  logic          b_sr_v [COLS][ROWS];
  logic [KW-1:0] b_sr_i [COLS][ROWS];

  systolic_array_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .VECTOR_LENGTH(K), .ACC_WIDTH(AW), .WAIT_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .pe_clear(pe_clear), .a_feed_valid(a_feed_valid), .a_feed_idx(a_feed_idx),
    .b_feed_valid(b_feed_valid), .b_feed_idx(b_feed_idx), .acc_valid_vec(acc_valid_vec),
    .acc_flat(acc_flat), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_col(res_col)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] fx_mul(input logic [AW-1:0] x, input logic [AW-1:0] y);
    logic signed [2*AW-1:0] p;
    p = $signed(x) * $signed(y);
    return p[AW+7:8];
  endfunction

  // PE(r,c) sees row r's feed delayed c cycles and column c's feed delayed r cycles.
  function automatic logic a_at_v(input int r, input int c);
    return (c == 0) ? a_feed_valid[r] : a_sr_v[r][c-1];
  endfunction
  function automatic logic [KW-1:0] a_at_i(input int r, input int c);
    return (c == 0) ? a_feed_idx[r*KW +: KW] : a_sr_i[r][c-1];
  endfunction
  function automatic logic b_at_v(input int r, input int c);
    return (r == 0) ? b_feed_valid[c] : b_sr_v[c][r-1];
  endfunction
  function automatic logic [KW-1:0] b_at_i(input int r, input int c);
    return (r == 0) ? b_feed_idx[c*KW +: KW] : b_sr_i[c][r-1];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      a_sr_v[r][0] <= a_feed_valid[r];
      a_sr_i[r][0] <= a_feed_idx[r*KW +: KW];
      for (int d = 1; d < COLS; d++) begin
        a_sr_v[r][d] <= a_sr_v[r][d-1];
        a_sr_i[r][d] <= a_sr_i[r][d-1];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      b_sr_v[c][0] <= b_feed_valid[c];
      b_sr_i[c][0] <= b_feed_idx[c*KW +: KW];
      for (int d = 1; d < ROWS; d++) begin
        b_sr_v[c][d] <= b_sr_v[c][d-1];
        b_sr_i[c][d] <= b_sr_i[c][d-1];
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rst || pe_clear) begin
          pe_acc[r][c] <= '0;
          pe_cnt[r][c] <= 0;
        end else if (a_at_v(r, c) && b_at_v(r, c)) begin
          pe_acc[r][c] <= pe_acc[r][c] + fx_mul(mat_a[r][a_at_i(r, c)], mat_b[b_at_i(r, c)][c]);
          pe_cnt[r][c] <= pe_cnt[r][c] + 1;
        end
      end
    end
  end

  always_comb begin
    acc_valid_model = '0;
    acc_flat        = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        acc_valid_model[r*COLS + c]          = (pe_cnt[r][c] == K);
        acc_flat[(r*COLS + c)*AW +: AW]      = pe_acc[r][c];
      end
    end
  end

  assign acc_valid_vec = force_en ? force_val : acc_valid_model;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] expect_c(input int r, input int c);
    logic [AW-1:0] s;
    s = '0;
    for (int k = 0; k < K; k++) s = s + fx_mul(mat_a[r][k], mat_b[k][c]);
    return s;
  endfunction

  task automatic push_expected;
    beat_t e;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        e.row  = RW'(r);
        e.col  = CW'(c);
        e.data = expect_c(r, c);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic load_identity;
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < K; k++) begin
        mat_a[i][k] = (i == k) ? 16'h0100 : 16'h0000;
        mat_b[k][i] = (i == k) ? 16'h0100 : 16'h0000;
      end
  endtask

  task automatic load_random;
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < K; k++) begin
        mat_a[i][k] = AW'($urandom_range(0, 1023)) - AW'(512);
        mat_b[k][i] = AW'($urandom_range(0, 1023)) - AW'(512);
      end
  endtask

  task automatic test_reset;
    bit saw_done;
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy, done, error, pe_clear, a_feed_valid, b_feed_valid, res_valid} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_ctrl got %b want 0", {busy, done, error, pe_clear, a_feed_valid, b_feed_valid, res_valid});
    end
    n_cmp++;
    if ({a_feed_idx, b_feed_idx, res_data, res_row, res_col} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_data got %h want 0", {a_feed_idx, b_feed_idx, res_data, res_row, res_col});
    end
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (a_feed_valid !== 4'b0111) begin
      n_bad++;
      $display("[TB] FAIL mid_feed_t2 got %b want 0111", a_feed_valid);
    end
    rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) saw_done = 1'b1;
      n_cmp++;
      if ({busy, pe_clear, a_feed_valid, b_feed_valid, res_valid} !== '0) begin
        n_bad++;
        $display("[TB] FAIL reset_abort got %b want 0", {busy, pe_clear, a_feed_valid, b_feed_valid, res_valid});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    n_cmp++;
    if ({saw_done, busy} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL reset_no_done got done_seen=%b busy=%b want 0 0", saw_done, busy);
    end
  endtask

  task automatic test_feed_schedule;
    logic [ROWS-1:0]    ea_v;
    logic [ROWS*KW-1:0] ea_i;
    logic [COLS-1:0]    eb_v;
    logic [COLS*KW-1:0] eb_i;
    bit                 got_done;
    load_identity();
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({pe_clear, busy} !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL clear_cycle got pe_clear=%b busy=%b want 1 1", pe_clear, busy);
    end
    for (int t = 0; t < 7; t++) begin
      tick();
      ea_v = '0; ea_i = '0; eb_v = '0; eb_i = '0;
      for (int r = 0; r < ROWS; r++)
        if (t >= r && t < r + K) begin
          ea_v[r] = 1'b1;
          ea_i[r*KW +: KW] = KW'(t - r);
        end
      for (int c = 0; c < COLS; c++)
        if (t >= c && t < c + K) begin
          eb_v[c] = 1'b1;
          eb_i[c*KW +: KW] = KW'(t - c);
        end
      n_cmp++;
      if ({pe_clear, a_feed_valid, a_feed_idx} !== {1'b0, ea_v, ea_i}) begin
        n_bad++;
        $display("[TB] FAIL feed_a t=%0d got %b/%b want %b/%b", t, a_feed_valid, a_feed_idx, ea_v, ea_i);
      end
      n_cmp++;
      if ({b_feed_valid, b_feed_idx} !== {eb_v, eb_i}) begin
        n_bad++;
        $display("[TB] FAIL feed_b t=%0d got %b/%b want %b/%b", t, b_feed_valid, b_feed_idx, eb_v, eb_i);
      end
    end
    tick();
    n_cmp++;
    if ({busy, a_feed_valid, b_feed_valid} !== 9'b1_0000_0000) begin
      n_bad++;
      $display("[TB] FAIL feed_end got busy=%b a=%b b=%b want 1 0000 0000", busy, a_feed_valid, b_feed_valid);
    end
    got_done = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      tick();
      if (done) got_done = 1'b1;
    end
    n_cmp++;
    if ({got_done, error} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL feed_job_done got done=%b error=%b want 1 0", got_done, error);
    end
    tick();
  endtask

  task automatic test_identity_job;
    bit    got_done;
    int    beats;
    beat_t e;
    load_identity();
    push_expected();
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    got_done = 1'b0;
    beats = 0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      tick();
      if (res_valid && res_ready) begin
        beats++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL ident_beat got extra beat %h want none", {res_row, res_col, res_data});
        end else begin
          e = exp_q.pop_front();
          if ({res_row, res_col, res_data} !== e) begin
            n_bad++;
            $display("[TB] FAIL ident_beat got r%0d c%0d %h want r%0d c%0d %h", res_row, res_col, res_data, e.row, e.col, e.data);
          end
        end
      end
      if (done) got_done = 1'b1;
    end
    n_cmp++;
    if ({got_done, error} !== 2'b10 || beats !== 16) begin
      n_bad++;
      $display("[TB] FAIL ident_done got done=%b error=%b beats=%0d want 1 0 16", got_done, error, beats);
    end
    tick();
    n_cmp++;
    if ({done, busy, res_valid} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL ident_pulse got done=%b busy=%b res_valid=%b want 0 0 0", done, busy, res_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    bit    got_done;
    bit    prev_stall;
    int    beats;
    int    stalls;
    beat_t e;
    beat_t prev_b;
    logic  pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    load_random();
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    got_done = 1'b0;
    prev_stall = 1'b0;
    prev_b = '0;
    beats = 0;
    stalls = 0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      tick();
      res_ready = pat[i % 4];
      if (prev_stall) begin
        n_cmp++;
        if (!res_valid || {res_row, res_col, res_data} !== prev_b) begin
          n_bad++;
          $display("[TB] FAIL stall_hold got v=%b %h want v=1 %h", res_valid, {res_row, res_col, res_data}, prev_b);
        end
      end
      if (res_valid && res_ready) begin
        beats++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL bp_beat got extra beat %h want none", {res_row, res_col, res_data});
        end else begin
          e = exp_q.pop_front();
          if ({res_row, res_col, res_data} !== e) begin
            n_bad++;
            $display("[TB] FAIL bp_beat got r%0d c%0d %h want r%0d c%0d %h", res_row, res_col, res_data, e.row, e.col, e.data);
          end
        end
      end
      if (res_valid && !res_ready) stalls++;
      prev_stall = res_valid && !res_ready;
      prev_b = {res_row, res_col, res_data};
      if (done) got_done = 1'b1;
    end
    res_ready = 1'b1;
    n_cmp++;
    if ({got_done, error} !== 2'b10 || beats !== 16 || stalls == 0) begin
      n_bad++;
      $display("[TB] FAIL bp_done got done=%b error=%b beats=%0d stalls=%0d want 1 0 16 >0", got_done, error, beats, stalls);
    end
    tick();
    exp_q.delete();
  endtask

  task automatic test_timeout;
    bit got_done;
    int cyc;
    int last_feed;
    int done_cyc;
    int beats;
    force_en = 1'b1;
    force_val = 16'hFFFE;
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    got_done = 1'b0;
    cyc = 0;
    last_feed = -1;
    done_cyc = -1;
    beats = 0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      tick();
      cyc++;
      if (a_feed_valid != '0 || b_feed_valid != '0) last_feed = cyc;
      if (res_valid) beats++;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
    end
    n_cmp++;
    if (!got_done || done_cyc - (last_feed + 1) !== TMO) begin
      n_bad++;
      $display("[TB] FAIL timeout_latency got done=%b after %0d cycles want 1 after %0d", got_done, done_cyc - (last_feed + 1), TMO);
    end
    n_cmp++;
    if ({error, beats} !== {1'b1, 32'd0}) begin
      n_bad++;
      $display("[TB] FAIL timeout_flags got error=%b beats=%0d want 1 0", error, beats);
    end
    tick();
    n_cmp++;
    if ({done, busy, error} !== 3'b001) begin
      n_bad++;
      $display("[TB] FAIL timeout_hold got done=%b busy=%b error=%b want 0 0 1", done, busy, error);
    end
    force_en = 1'b0;
  endtask

  task automatic test_ignore_start;
    bit    got_done;
    int    clears;
    int    feed_cycles;
    int    beats;
    beat_t e;
    load_identity();
    res_ready = 1'b1;
    n_cmp++;
    if (error !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL error_until_start got %b want 1", error);
    end
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({pe_clear, error} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL start_clears_error got pe_clear=%b error=%b want 1 0", pe_clear, error);
    end
    clears = 1;
    feed_cycles = 0;
    beats = 0;
    got_done = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      tick();
      start = (i == 2);
      if (pe_clear) clears++;
      if (a_feed_valid != '0) feed_cycles++;
      if (res_valid && res_ready) begin
        beats++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL ign_beat got extra beat %h want none", {res_row, res_col, res_data});
        end else begin
          e = exp_q.pop_front();
          if ({res_row, res_col, res_data} !== e) begin
            n_bad++;
            $display("[TB] FAIL ign_beat got r%0d c%0d %h want r%0d c%0d %h", res_row, res_col, res_data, e.row, e.col, e.data);
          end
        end
      end
      if (done) begin
        got_done = 1'b1;
        start = 1'b1;
      end
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, pe_clear, done} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL start_in_done got busy=%b pe_clear=%b done=%b want 0 0 0", busy, pe_clear, done);
    end
    n_cmp++;
    if (!got_done || clears !== 1 || feed_cycles !== 7 || beats !== 16) begin
      n_bad++;
      $display("[TB] FAIL start_in_feed got done=%b clears=%0d feed=%0d beats=%0d want 1 1 7 16", got_done, clears, feed_cycles, beats);
    end
    exp_q.delete();
    load_random();
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    got_done = 1'b0;
    beats = 0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      tick();
      if (res_valid && res_ready) begin
        beats++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL b2b_beat got extra beat %h want none", {res_row, res_col, res_data});
        end else begin
          e = exp_q.pop_front();
          if ({res_row, res_col, res_data} !== e) begin
            n_bad++;
            $display("[TB] FAIL b2b_beat got r%0d c%0d %h want r%0d c%0d %h", res_row, res_col, res_data, e.row, e.col, e.data);
          end
        end
      end
      if (done) got_done = 1'b1;
    end
    n_cmp++;
    if ({got_done, error} !== 2'b10 || beats !== 16) begin
      n_bad++;
      $display("[TB] FAIL b2b_done got done=%b error=%b beats=%0d want 1 0 16", got_done, error, beats);
    end
    tick();
    exp_q.delete();
  endtask

  initial begin
    $display("[TB] systolic_array_ctrl bench starting");
    test_reset();
    test_feed_schedule();
    test_identity_job();
    test_backpressure();
    test_timeout();
    test_ignore_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
